fir_detect_core: RTL and testbench

//  Parametrised successor of the fixed int8 filter+detector datapath: TAPS-tap FIR with runtime-loadable

---
 rtl/fir_detect_pkg.sv | 41 ++++
 rtl/fir_detect_fsm.sv | 138 +++++++++++++
 rtl/fir_detect_core.sv | 140 ++++++++++++++
 tb/tb_fir_detect_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_detect_pkg.sv
// ---------------------------------------------------------------------------
// fir_detect_pkg
//   Shared types and helpers for the FIR + threshold-detector datapath.
//   - det_state_e : detector FSM states
//   - acc_w()     : accumulator width that cannot overflow for a given config
//   - round_shr() : add half an LSB, then arithmetic shift right (round half up)
//   - sat_w()     : clamp a wide signed value into a w-bit signed range
// ---------------------------------------------------------------------------
package fir_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        DET  = 2'd2,
        REL  = 2'd3
    } det_state_e;

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Bias by 2^(frac-1) before the shift so ties round toward +inf.
    function automatic logic signed [63:0] round_shr(input logic signed [63:0] v,
                                                     input int frac);
        logic signed [63:0] bias;
        bias = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
        return (v + bias) >>> frac;
    endfunction

    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                                 input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_detect_fsm.sv
// ---------------------------------------------------------------------------
// fir_detect_fsm
//   Hysteresis/hold threshold detector on the filtered sample stream.
//   Advances only when a filtered sample is valid and the detector is enabled.
//   Ports:
//     clk_i, rst_ni     clock, asynchronous active-low reset
//     enable_i          0 forces IDLE (det_count is retained)
//     vld_i, post_i     filtered sample and its valid
//     thr_hi_i/thr_lo_i unsigned arm / release thresholds on |post|
//     hold_len_i        consecutive qualifying samples to change state (0 acts as 1)
//     detected_o        registered detection flag (DET or REL)
//     det_count_o       saturating count of detected rising edges
// ---------------------------------------------------------------------------
module fir_detect_fsm
    import fir_detect_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int HOLD_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     vld_i,
    input  logic signed [DATA_W-1:0] post_i,
    input  logic        [DATA_W-1:0] thr_hi_i,
    input  logic        [DATA_W-1:0] thr_lo_i,
    input  logic        [HOLD_W-1:0] hold_len_i,
    output logic                     detected_o,
    output logic        [15:0]       det_count_o
);

    det_state_e        state_q;
    logic [HOLD_W-1:0] cnt_q;
    logic              detected_q;
    logic [15:0]       det_count_q;

    logic [DATA_W:0]   ext_d;
    logic [DATA_W:0]   mag_d;
    logic              above_hi_d;
    logic              below_lo_d;
    logic [HOLD_W:0]   hold_d;
    logic [HOLD_W:0]   cnt_inc_d;
    logic              hold_one_d;
    logic              hold_hit_d;
    logic [15:0]       det_count_inc_d;

    always_comb begin
        // One extra bit so |-2^(DATA_W-1)| is representable.
        ext_d           = {post_i[DATA_W-1], post_i};
        mag_d           = post_i[DATA_W-1] ? (~ext_d + (DATA_W+1)'(1)) : ext_d;
        above_hi_d      = (mag_d >= {1'b0, thr_hi_i});
        below_lo_d      = (mag_d <  {1'b0, thr_lo_i});
        hold_d          = (hold_len_i == '0) ? (HOLD_W+1)'(1) : {1'b0, hold_len_i};
        hold_one_d      = (hold_d == (HOLD_W+1)'(1));
        cnt_inc_d       = {1'b0, cnt_q} + (HOLD_W+1)'(1);
        hold_hit_d      = (cnt_inc_d >= hold_d);
        det_count_inc_d = (det_count_q == 16'hFFFF) ? det_count_q : det_count_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            detected_q  <= 1'b0;
            det_count_q <= '0;
        end else if (!enable_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            detected_q <= 1'b0;
        end else if (vld_i) begin
            case (state_q)
                IDLE: begin
                    if (above_hi_d) begin
                        if (hold_one_d) begin
                            state_q     <= DET;
                            cnt_q       <= '0;
                            detected_q  <= 1'b1;
                            det_count_q <= det_count_inc_d;
                        end else begin
                            state_q <= ARM;
                            cnt_q   <= HOLD_W'(1);
                        end
                    end
                end
                ARM: begin
                    if (above_hi_d) begin
                        if (hold_hit_d) begin
                            state_q     <= DET;
                            cnt_q       <= '0;
                            detected_q  <= 1'b1;
                            det_count_q <= det_count_inc_d;
                        end else begin
                            cnt_q <= cnt_inc_d[HOLD_W-1:0];
                        end
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                DET: begin
                    if (below_lo_d) begin
                        if (hold_one_d) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            detected_q <= 1'b0;
                        end else begin
                            state_q <= REL;
                            cnt_q   <= HOLD_W'(1);
                        end
                    end
                end
                REL: begin
                    if (below_lo_d) begin
                        if (hold_hit_d) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            detected_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc_d[HOLD_W-1:0];
                        end
                    end else begin
                        state_q <= DET;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    detected_q <= 1'b0;
                end
            endcase
        end
    end

    assign detected_o  = detected_q;
    assign det_count_o = det_count_q;

endmodule

// File: rtl/fir_detect_core.sv
// ---------------------------------------------------------------------------
// fir_detect_core
//   TAPS-tap FIR with runtime-loadable coefficients, round/saturate back to
//   DATA_W, followed by the hysteresis/hold detector. Fixed latency 4:
//   S0 capture+shift, S1 products, S2 adder tree, S3 round+saturate.
//   Ports:
//     clk, reset              clock, asynchronous active-low reset
//     enable                  detector enable (filter always runs)
//     in_valid, pre           input sample and valid
//     coef_wr/addr/data       coefficient write port (addr 0 = newest sample)
//     thr_hi, thr_lo, hold_len detector configuration
//     out_valid, post         filtered sample (post holds between valids)
//     detected, det_count     detector flag and rising-edge counter
// ---------------------------------------------------------------------------
module fir_detect_core
    import fir_detect_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 10,
    parameter int COEF_FRAC = 6,
    parameter int TAPS      = 8,
    parameter int HOLD_W    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   pre,
    input  logic                       coef_wr,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic        [DATA_W-1:0]   thr_hi,
    input  logic        [DATA_W-1:0]   thr_lo,
    input  logic        [HOLD_W-1:0]   hold_len,
    output logic                       out_valid,
    output logic signed [DATA_W-1:0]   post,
    output logic                       detected,
    output logic        [15:0]         det_count
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

    logic signed [DATA_W-1:0] dl_p0 [TAPS];
    logic                     vld_p0;
    logic signed [PROD_W-1:0] prod_p1 [TAPS];
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  acc_p2;
    logic                     vld_p2;
    logic signed [DATA_W-1:0] post_q;
    logic                     out_valid_q;

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic                     coef_wr_q;
    logic [ADDR_W-1:0]        coef_addr_q;
    logic signed [COEF_W-1:0] coef_data_q;

    logic signed [ACC_W-1:0]  sum_d;
    logic signed [DATA_W-1:0] post_d;

    // Control, delay line, coefficients and output register.
    // The coefficient write is retired one cycle late so that a sample
    // arriving in the same cycle as the write still multiplies by the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                dl_p0[i]  <= '0;
                coef_q[i] <= '0;
            end
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            out_valid_q <= 1'b0;
            post_q      <= '0;
            coef_wr_q   <= 1'b0;
            coef_addr_q <= '0;
            coef_data_q <= '0;
        end else begin
            // S0: capture + shift
            vld_p0 <= in_valid;
            if (in_valid) begin
                dl_p0[0] <= pre;
                for (int i = 1; i < TAPS; i++) begin
                    dl_p0[i] <= dl_p0[i-1];
                end
            end
            coef_wr_q   <= coef_wr;
            coef_addr_q <= coef_addr;
            coef_data_q <= coef_data;
            if (coef_wr_q && (32'(coef_addr_q) < TAPS)) begin
                coef_q[coef_addr_q] <= coef_data_q;
            end
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            // S3: round + saturate
            out_valid_q <= vld_p2;
            if (vld_p2) begin
                post_q <= post_d;
            end
        end
    end

    // S1: products, S2: adder tree (data only, qualified by the valids)
    always_ff @(posedge clk) begin
        for (int i = 0; i < TAPS; i++) begin
            prod_p1[i] <= dl_p0[i] * coef_q[i];
        end
        acc_p2 <= sum_d;
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_d = sum_d + ACC_W'(prod_p1[i]);
        end
    end

    assign post_d = DATA_W'(sat_w(round_shr(64'(acc_p2), COEF_FRAC), DATA_W));

    assign out_valid = out_valid_q;
    assign post      = post_q;

    fir_detect_fsm #(
        .DATA_W (DATA_W),
        .HOLD_W (HOLD_W)
    ) u_fsm (
        .clk_i       (clk),
        .rst_ni      (reset),
        .enable_i    (enable),
        .vld_i       (out_valid_q),
        .post_i      (post_q),
        .thr_hi_i    (thr_hi),
        .thr_lo_i    (thr_lo),
        .hold_len_i  (hold_len),
        .detected_o  (detected),
        .det_count_o (det_count)
    );

endmodule

// File: tb/tb_fir_detect_core.sv
// Bench for fir_detect_core: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the filter and detector.
module tb_fir_detect_core;

  localparam int DATA_W    = 8;
  localparam int COEF_W    = 10;
  localparam int COEF_FRAC = 6;
  localparam int TAPS      = 8;
  localparam int HOLD_W    = 4;

  logic                     clk       = 1'b0;
  logic                     reset     = 1'b0;
  logic                     enable    = 1'b0;
  logic                     in_valid  = 1'b0;
  logic signed [DATA_W-1:0] pre       = '0;
  logic                     coef_wr   = 1'b0;
  logic [2:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic [DATA_W-1:0]        thr_hi    = 8'd255;
  logic [DATA_W-1:0]        thr_lo    = 8'd0;
  logic [HOLD_W-1:0]        hold_len  = 4'd1;
  logic                     out_valid;
  logic signed [DATA_W-1:0] post;
  logic                     detected;
  logic [15:0]              det_count;

  fir_detect_core #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .TAPS(TAPS), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .pre(pre),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .hold_len(hold_len),
    .out_valid(out_valid), .post(post), .detected(detected), .det_count(det_count)
  );

  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct { int t; int val; } exp_t;
  exp_t exp_q[$];
  int   m_coef[TAPS];
  int   m_hist[TAPS];
  int   m_det = 0;
  int   m_run = 0;
  int   m_cnt = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Filter output of the current history: sum, round half up, floor shift, clamp.
  function automatic int ref_fir();
    longint acc;
    longint r;
    longint one;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(m_coef[i]) * longint'(m_hist[i]);
    one = longint'(1) << COEF_FRAC;
    r   = acc + (one / 2);
    if (r >= 0) r = r / one;
    else        r = -((-r + one - 1) / one);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  // Detector: count consecutive samples that argue for leaving the current state.
  task automatic model_detect(input int v);
    int mag;
    int h;
    mag = (v < 0) ? -v : v;
    h   = (hold_len == 0) ? 1 : int'(hold_len);
    if (m_det == 0) begin
      if (mag >= int'(thr_hi)) m_run++; else m_run = 0;
      if (m_run >= h) begin
        m_det = 1;
        m_run = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      if (mag < int'(thr_lo)) m_run++; else m_run = 0;
      if (m_run >= h) begin
        m_det = 0;
        m_run = 0;
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) begin
      m_coef[i] = 0;
      m_hist[i] = 0;
    end
    m_det = 0;
    m_run = 0;
    m_cnt = 0;
  endtask

  // Per-cycle monitor on the falling edge.
  initial forever begin
    bit   ev;
    exp_t e;
    @(negedge clk);
    if (reset) begin
      ev = (exp_q.size() > 0) && (exp_q[0].t == cyc);
      check("detected", detected, m_det);
      check("det_count", det_count, m_cnt);
      check("out_valid", out_valid, ev);
      if (ev) begin
        e = exp_q.pop_front();
        check("post", post, e.val);
        if (enable) model_detect(e.val);
      end
      if (!enable) begin
        m_det = 0;
        m_run = 0;
      end
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input bit v, input int s, input bit wr = 1'b0,
                      input int a = 0, input int d = 0);
    in_valid  = v;
    pre       = 8'(s);
    coef_wr   = wr;
    coef_addr = 3'(a);
    coef_data = 10'(d);
    if (v) begin
      for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = s;
      exp_q.push_back('{t: cyc + 4, val: ref_fir()});
    end
    if (wr) m_coef[a] = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".post"}, post, 0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".detected"}, detected, 0);
    check({tag, ".det_count"}, det_count, 0);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    coef_wr  = 1'b0;
    clear_model();
    #1;
    check_outputs_zero("reset_now");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset  = 1'b1;
    enable = 1'b1;

    // Identity
    step(1'b0, 0, 1'b1, 0, 64);
    idle(2);
    step(1'b1, -5); step(1'b1, 17); step(1'b1, 127); step(1'b1, -128);
    idle(6);

    // Rounding
    step(1'b0, 0, 1'b1, 0, 32);
    idle(2);
    step(1'b1, 3); step(1'b1, -3); step(1'b1, 1);
    idle(6);

    // Saturation
    for (int i = 0; i < TAPS; i++) step(1'b0, 0, 1'b1, i, 64);
    idle(2);
    for (int i = 0; i < 10; i++) step(1'b1, 100);
    for (int i = 0; i < 10; i++) step(1'b1, -100);
    idle(6);

    // Detector with hysteresis and hold
    do_reset();
    thr_hi = 8'd50; thr_lo = 8'd20; hold_len = 4'd3;
    step(1'b0, 0, 1'b1, 0, 64);
    idle(2);
    step(1'b1, 60); step(1'b1, 60); step(1'b1, 10);
    step(1'b1, 60); step(1'b1, 60); step(1'b1, 60);
    step(1'b1, 30); step(1'b1, 10); step(1'b1, 10); step(1'b1, 30);
    step(1'b1, 10); step(1'b1, 10); step(1'b1, 10);
    idle(8);
    check("det_scn.det_count", det_count, 1);
    check("det_scn.detected", detected, 0);

    // Gaps preserved
    step(1'b1, 7); step(1'b0, 0); step(1'b0, 0); step(1'b1, 9);
    idle(6);

    // Coefficient write coinciding with a sample
    step(1'b1, 40, 1'b1, 0, -64);
    step(1'b1, 40);
    idle(6);
    step(1'b0, 0, 1'b1, 0, 64);
    idle(2);

    // Enable dropped while detecting
    hold_len = 4'd1;
    step(1'b1, 100);
    idle(6);
    check("en.detected_before", detected, 1);
    enable = 1'b0;
    idle(1);
    check("en.detected_after", detected, 0);
    check("en.det_count_kept", det_count, 2);
    enable = 1'b1;
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        hi       = int'($urandom_range(0, 130));
        thr_hi   = 8'(hi);
        thr_lo   = 8'($urandom_range(0, hi));
        hold_len = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 99) < 8) begin
        if ($urandom_range(0, 1) == 1)
          step($urandom_range(0, 99) < 70, int'($urandom_range(0, 255)) - 128, 1'b1,
               int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 1023)) - 512);
        else
          step($urandom_range(0, 99) < 70, int'($urandom_range(0, 255)) - 128, 1'b1,
               int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 80)) - 40);
      end else begin
        step($urandom_range(0, 99) < 70, int'($urandom_range(0, 255)) - 128);
      end
    end
    enable = 1'b1;
    idle(6);

    // Reset with samples in flight
    step(1'b1, 50); step(1'b1, -60); step(1'b1, 70);
    do_reset();
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
